// File: rtl/reg_stream_fifo_bridge.sv
// Register-slot FIFO bridge: host writes feed a TX stream FIFO, an RX stream FIFO feeds host reads.
// TX word visible on the stream one cycle after the write; RX stalls via rx_tready when full, TX writes to a full FIFO are dropped.

module reg_stream_fifo_bridge_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [W-1:0]     head_dat,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = CNT_W - 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  // Flush wins over any same-cycle transfer on this FIFO.
  assign do_push  = push & ~full & ~flush;
  assign do_pop   = pop & ~empty & ~flush;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module reg_stream_fifo_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic [DATA_WIDTH-1:0]   reg_wrdout,
  input  logic [DATA_WIDTH/8-1:0] tx_wrByteStrobe,
  input  logic                    rx_rdStrobe,
  output logic [DATA_WIDTH-1:0]   rx_rddin,
  input  logic [DATA_WIDTH/8-1:0] ctrl_wrByteStrobe,
  output logic [DATA_WIDTH-1:0]   stat_rddin,
  output logic [DATA_WIDTH-1:0]   tx_tdata,
  output logic                    tx_tvalid,
  input  logic                    tx_tready,
  input  logic [DATA_WIDTH-1:0]   rx_tdata,
  input  logic                    rx_tvalid,
  output logic                    rx_tready
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tx_word;
  logic [DATA_WIDTH-1:0] rx_head;
  logic [CNT_W-1:0]      tx_count;
  logic [CNT_W-1:0]      rx_count;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic                  tx_push, rx_push;
  logic                  ctrl_wr, tx_flush, rx_flush, clr_sticky;
  logic                  ovf_set, unf_set;
  logic                  tx_overflow, rx_underflow;
  logic                  unused_ctrl_bits;

  assign unused_ctrl_bits = ^ctrl_wrByteStrobe[NB-1:1];

  assign ctrl_wr    = ctrl_wrByteStrobe[0];
  assign tx_flush   = ctrl_wr & reg_wrdout[0];
  assign rx_flush   = ctrl_wr & reg_wrdout[1];
  assign clr_sticky = ctrl_wr & reg_wrdout[2];

  always_comb begin
    tx_word = '0;
    for (int b = 0; b < NB; b++) begin
      if (tx_wrByteStrobe[b]) tx_word[8*b +: 8] = reg_wrdout[8*b +: 8];
    end
  end

  assign tx_push = |tx_wrByteStrobe;
  assign rx_push = rx_tvalid & rx_tready;

  reg_stream_fifo_bridge_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETN),
    .push     (tx_push),
    .push_dat (tx_word),
    .pop      (tx_tready),
    .flush    (tx_flush),
    .head_dat (tx_tdata),
    .count    (tx_count),
    .full     (tx_full),
    .empty    (tx_empty)
  );

  reg_stream_fifo_bridge_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETN),
    .push     (rx_push),
    .push_dat (rx_tdata),
    .pop      (rx_rdStrobe),
    .flush    (rx_flush),
    .head_dat (rx_head),
    .count    (rx_count),
    .full     (rx_full),
    .empty    (rx_empty)
  );

  assign tx_tvalid = ~tx_empty;
  assign rx_tready = ~rx_full;
  assign rx_rddin  = rx_empty ? '0 : rx_head;

  // Errors hidden by a same-cycle flush are not reported; a new error beats a clear.
  assign ovf_set = tx_push & tx_full & ~tx_flush;
  assign unf_set = rx_rdStrobe & rx_empty & ~rx_flush;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      if (ovf_set)         tx_overflow <= 1'b1;
      else if (clr_sticky) tx_overflow <= 1'b0;
      if (unf_set)         rx_underflow <= 1'b1;
      else if (clr_sticky) rx_underflow <= 1'b0;
    end
  end

  always_comb begin
    stat_rddin             = '0;
    stat_rddin[0]          = tx_full;
    stat_rddin[1]          = tx_empty;
    stat_rddin[2]          = rx_full;
    stat_rddin[3]          = rx_empty;
    stat_rddin[4]          = tx_overflow;
    stat_rddin[5]          = rx_underflow;
    stat_rddin[8 +: CNT_W]  = tx_count;
    stat_rddin[16 +: CNT_W] = rx_count;
  end
endmodule

// File: tb/tb_reg_stream_fifo_bridge.sv
// Bench for reg_stream_fifo_bridge: directed test-plan cases plus random traffic against a queue-based model.
module tb_reg_stream_fifo_bridge;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] reg_wrdout = '0;
  logic [3:0]    tx_wrByteStrobe = '0;
  logic          rx_rdStrobe = 1'b0;
  logic [DW-1:0] rx_rddin;
  logic [3:0]    ctrl_wrByteStrobe = '0;
  logic [DW-1:0] stat_rddin;
  logic [DW-1:0] tx_tdata;
  logic          tx_tvalid;
  logic          tx_tready = 1'b0;
  logic [DW-1:0] rx_tdata = '0;
  logic          rx_tvalid = 1'b0;
  logic          rx_tready;

  int errors = 0;
  int checks = 0;

  // Expected FIFO contents and sticky flags.
  logic [DW-1:0] tx_exp[$];
  logic [DW-1:0] rx_exp[$];
  bit m_ovf = 0;
  bit m_unf = 0;

  always #5 clk = ~clk;

  reg_stream_fifo_bridge #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .S_AXI_ACLK        (clk),
    .S_AXI_ARESETN     (rst_n),
    .reg_wrdout        (reg_wrdout),
    .tx_wrByteStrobe   (tx_wrByteStrobe),
    .rx_rdStrobe       (rx_rdStrobe),
    .rx_rddin          (rx_rddin),
    .ctrl_wrByteStrobe (ctrl_wrByteStrobe),
    .stat_rddin        (stat_rddin),
    .tx_tdata          (tx_tdata),
    .tx_tvalid         (tx_tvalid),
    .tx_tready         (tx_tready),
    .rx_tdata          (rx_tdata),
    .rx_tvalid         (rx_tvalid),
    .rx_tready         (rx_tready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [31:0] model_stat();
    logic [31:0] s;
    s        = '0;
    s[0]     = (tx_exp.size() == DEPTH);
    s[1]     = (tx_exp.size() == 0);
    s[2]     = (rx_exp.size() == DEPTH);
    s[3]     = (rx_exp.size() == 0);
    s[4]     = m_ovf;
    s[5]     = m_unf;
    s[15:8]  = 8'(tx_exp.size());
    s[23:16] = 8'(rx_exp.size());
    return s;
  endfunction

  // Reference model: applies each cycle's events at the clock edge using pre-edge occupancy.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        tx_exp.delete();
        rx_exp.delete();
        m_ovf = 0;
        m_unf = 0;
      end else begin
        bit tx_fl, rx_fl, clr, tx_was_full, rx_was_full, tx_was_empty, rx_was_empty;
        tx_fl        = ctrl_wrByteStrobe[0] && reg_wrdout[0];
        rx_fl        = ctrl_wrByteStrobe[0] && reg_wrdout[1];
        clr          = ctrl_wrByteStrobe[0] && reg_wrdout[2];
        tx_was_full  = (tx_exp.size() == DEPTH);
        tx_was_empty = (tx_exp.size() == 0);
        rx_was_full  = (rx_exp.size() == DEPTH);
        rx_was_empty = (rx_exp.size() == 0);
        if (clr) begin
          m_ovf = 0;
          m_unf = 0;
        end
        if (tx_wrByteStrobe != 0 && tx_was_full && !tx_fl) m_ovf = 1;
        if (rx_rdStrobe && rx_was_empty && !rx_fl) m_unf = 1;
        if (tx_fl) tx_exp.delete();
        else begin
          if (tx_tready && !tx_was_empty) void'(tx_exp.pop_front());
          if (tx_wrByteStrobe != 0 && !tx_was_full) tx_exp.push_back(reg_wrdout & byte_mask(tx_wrByteStrobe));
        end
        if (rx_fl) rx_exp.delete();
        else begin
          if (rx_rdStrobe && !rx_was_empty) void'(rx_exp.pop_front());
          if (rx_tvalid && !rx_was_full) rx_exp.push_back(rx_tdata);
        end
      end
    end
  end

  // Monitor: compares every visible output mid-cycle against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("mon_tx_tvalid", 32'(tx_tvalid), 32'(tx_exp.size() != 0));
        if (tx_exp.size() != 0) chk("mon_tx_tdata", tx_tdata, tx_exp[0]);
        chk("mon_rx_tready", 32'(rx_tready), 32'(rx_exp.size() < DEPTH));
        chk("mon_rx_rddin", rx_rddin, (rx_exp.size() != 0) ? rx_exp[0] : 32'h0);
        chk("mon_stat", stat_rddin, model_stat());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    tx_wrByteStrobe   = '0;
    ctrl_wrByteStrobe = '0;
    rx_rdStrobe       = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] got[$];
    logic [DW-1:0] rx_vals[4];
    int n;
    int rdy_pct;
    int rd_pct;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_stat", stat_rddin, 32'h0000_000A);
    chk("reset_tvalid", 32'(tx_tvalid), 32'd0);
    chk("reset_rx_tready", 32'(rx_tready), 32'd1);
    chk("reset_rx_rddin", rx_rddin, 32'h0);
    rst_n = 1'b1;
    cyc();

    // Single full-word write passes straight through.
    tx_tready = 1'b1;
    reg_wrdout = 32'hDEAD_BEEF;
    tx_wrByteStrobe = 4'hF;
    cyc();
    chk("t1_tvalid", 32'(tx_tvalid), 32'd1);
    chk("t1_tdata", tx_tdata, 32'hDEAD_BEEF);
    cyc();
    chk("t1_tvalid_after", 32'(tx_tvalid), 32'd0);
    chk("t1_tx_empty", 32'(stat_rddin[1]), 32'd1);

    // Partial byte strobes zero the unstrobed bytes.
    tx_tready = 1'b0;
    reg_wrdout = 32'h1122_3344;
    tx_wrByteStrobe = 4'b0101;
    cyc();
    chk("t2_tdata", tx_tdata, 32'h0022_0044);
    tx_tready = 1'b1;
    cyc();
    tx_tready = 1'b0;

    // Overflow: 17 writes into a stalled 16-deep FIFO.
    for (int i = 0; i < 17; i++) begin
      reg_wrdout = 32'h100 + i;
      tx_wrByteStrobe = 4'hF;
      cyc();
    end
    chk("t3_stat_full", stat_rddin, 32'h0000_1019);
    tx_tready = 1'b1;
    n = 0;
    while (tx_tvalid && n < 40) begin
      got.push_back(tx_tdata);
      cyc();
      n++;
    end
    chk("t3_drain_count", 32'(got.size()), 32'd16);
    if (got.size() == 16) begin
      chk("t3_first", got[0], 32'h100);
      chk("t3_last", got[15], 32'h10F);
    end

    // RX beats, reads including one underflow, then sticky clear.
    rx_vals = '{32'hA, 32'hB, 32'hC, 32'h0};
    for (int i = 0; i < 3; i++) begin
      rx_tvalid = 1'b1;
      rx_tdata = rx_vals[i];
      cyc();
    end
    rx_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_rdStrobe = 1'b1;
      #1;
      chk("t4_rx_rddin", rx_rddin, rx_vals[i]);
      cyc();
    end
    chk("t4_underflow", 32'(stat_rddin[5]), 32'd1);
    reg_wrdout = 32'h4;
    ctrl_wrByteStrobe = 4'h1;
    cyc();
    chk("t4_sticky_clr", 32'(stat_rddin[5:4]), 32'd0);

    // RX full: simultaneous read and beat pops only, beat lands next cycle.
    for (int i = 0; i < 16; i++) begin
      rx_tvalid = 1'b1;
      rx_tdata = 32'h200 + i;
      cyc();
    end
    rx_tdata = 32'h77;
    chk("t5_rx_tready_full", 32'(rx_tready), 32'd0);
    rx_rdStrobe = 1'b1;
    #1;
    chk("t5_rx_head", rx_rddin, 32'h200);
    cyc();
    chk("t5_rx_tready_after_pop", 32'(rx_tready), 32'd1);
    cyc();
    rx_tvalid = 1'b0;
    chk("t5_rx_count", 32'(stat_rddin[20:16]), 32'd16);
    reg_wrdout = 32'h2;
    ctrl_wrByteStrobe = 4'h1;
    cyc();
    chk("t5_rx_flushed", 32'(stat_rddin[20:16]), 32'd0);

    // TX flush coincident with a push discards everything, no overflow.
    tx_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      reg_wrdout = 32'h300 + i;
      tx_wrByteStrobe = 4'hF;
      cyc();
    end
    chk("t6_tx_count5", 32'(stat_rddin[12:8]), 32'd5);
    reg_wrdout = 32'h1;
    tx_wrByteStrobe = 4'hF;
    ctrl_wrByteStrobe = 4'h1;
    cyc();
    chk("t6_tx_count0", 32'(stat_rddin[12:8]), 32'd0);
    chk("t6_tvalid", 32'(tx_tvalid), 32'd0);
    chk("t6_overflow", 32'(stat_rddin[4]), 32'd0);

    // Random traffic; the monitor checks every cycle.
    rdy_pct = 50;
    rd_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        rdy_pct = $urandom_range(0, 100);
        rd_pct = $urandom_range(0, 100);
      end
      tx_tready = ($urandom_range(0, 99) < rdy_pct);
      reg_wrdout = $urandom;
      if ($urandom_range(0, 2) != 0) tx_wrByteStrobe = 4'($urandom_range(0, 15));
      rx_tvalid = 1'($urandom_range(0, 1));
      rx_tdata = $urandom;
      rx_rdStrobe = ($urandom_range(0, 99) < rd_pct);
      if ($urandom_range(0, 59) == 0) ctrl_wrByteStrobe = 4'($urandom_range(0, 15));
      cyc();
    end

    // Reset asserted mid-stream with both FIFOs holding data.
    rx_tvalid = 1'b0;
    tx_tready = 1'b0;
    reg_wrdout = 32'h7;
    ctrl_wrByteStrobe = 4'h1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      reg_wrdout = 32'h400 + i;
      tx_wrByteStrobe = 4'hF;
      rx_tvalid = 1'b1;
      rx_tdata = 32'h500 + i;
      cyc();
    end
    tx_tready = 1'b1;
    chk("t7_pre_tvalid", 32'(tx_tvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_tvalid", 32'(tx_tvalid), 32'd0);
    chk("t7_rst_rx_tready", 32'(rx_tready), 32'd1);
    chk("t7_rst_rx_rddin", rx_rddin, 32'h0);
    chk("t7_rst_stat", stat_rddin, 32'h0000_000A);
    rx_tvalid = 1'b0;
    #3;
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("t7_post_stat", stat_rddin, 32'h0000_000A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
